// File: rtl/inst_encoder.sv
// inst_encoder: accepts one RV32I instruction description per handshake,
// encodes it, rejects illegal encodings, and writes legal words sequentially
// into an instruction memory starting at BASE_ADDR.
module inst_encoder #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_kind,
  input  logic [2:0]            req_funct3,
  input  logic                  req_alt,
  input  logic [4:0]            req_rd,
  input  logic [4:0]            req_rs1,
  input  logic [4:0]            req_rs2,
  input  logic [31:0]           req_imm,
  input  logic                  req_last,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  done,
  output logic                  err,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    WRITE  = 2'd2,
    FULL   = 2'd3
  } state_t;

  localparam logic [3:0] K_R      = 4'd0;
  localparam logic [3:0] K_IARITH = 4'd1;
  localparam logic [3:0] K_LOAD   = 4'd2;
  localparam logic [3:0] K_STORE  = 4'd3;
  localparam logic [3:0] K_BRANCH = 4'd4;
  localparam logic [3:0] K_LUI    = 4'd5;
  localparam logic [3:0] K_AUIPC  = 4'd6;
  localparam logic [3:0] K_JAL    = 4'd7;
  localparam logic [3:0] K_JALR   = 4'd8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [DEPTH_LOG2-1:0] PTR_MAX = {DEPTH_LOG2{1'b1}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   wr_ptr_r;
  logic [3:0]              kind_r;
  logic [2:0]              funct3_r;
  logic                    alt_r;
  logic [4:0]              rd_r;
  logic [4:0]              rs1_r;
  logic [4:0]              rs2_r;
  logic [31:0]             imm_r;
  logic                    last_r;
  logic [31:0]             enc_word_r;
  logic [31:0]             enc_word_s;
  logic                    legal_s;

  // An immediate fits N signed bits when all bits from N-1 upward agree.
  function automatic logic fits_s12(input logic [31:0] v);
    return (v[31:11] == 21'h00_0000) || (v[31:11] == 21'h1F_FFFF);
  endfunction

  function automatic logic fits_s13(input logic [31:0] v);
    return (v[31:12] == 20'h0_0000) || (v[31:12] == 20'hF_FFFF);
  endfunction

  function automatic logic fits_s21(input logic [31:0] v);
    return (v[31:20] == 12'h000) || (v[31:20] == 12'hFFF);
  endfunction

  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

  // Build the RV32I word; unused fields of each format stay zero.
  function automatic logic [31:0] encode_word(
    input logic [3:0]  kind,
    input logic [2:0]  f3,
    input logic        alt,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [6:0] funct7;
    funct7 = alt ? 7'b0100000 : 7'b0000000;
    case (kind)
      K_R:      return {funct7, rs2, rs1, f3, rd, OP_R};
      K_IARITH: begin
        if (is_shift(f3)) begin
          return {funct7, imm[4:0], rs1, f3, rd, OP_IARITH};
        end else begin
          return {imm[11:0], rs1, f3, rd, OP_IARITH};
        end
      end
      K_LOAD:   return {imm[11:0], rs1, f3, rd, OP_LOAD};
      K_STORE:  return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
      K_BRANCH: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      K_LUI:    return {imm[31:12], rd, OP_LUI};
      K_AUIPC:  return {imm[31:12], rd, OP_AUIPC};
      K_JAL:    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      K_JALR:   return {imm[11:0], rs1, f3, rd, OP_JALR};
      default:  return 32'h0000_0000;
    endcase
  endfunction

  // Reject immediates that do not fit the format and reserved funct3/funct7 combinations.
  function automatic logic is_legal(
    input logic [3:0]  kind,
    input logic [2:0]  f3,
    input logic        alt,
    input logic [31:0] imm
  );
    case (kind)
      K_R:      return !(alt && (f3 != 3'b000) && (f3 != 3'b101));
      K_IARITH: begin
        if (is_shift(f3)) begin
          return (imm[31:5] == 27'h000_0000) && !(alt && (f3 == 3'b001));
        end else begin
          return fits_s12(imm);
        end
      end
      K_LOAD:   return fits_s12(imm) && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      K_STORE:  return fits_s12(imm) && (f3 <= 3'b010);
      K_BRANCH: return fits_s13(imm) && !imm[0] && (f3 != 3'b010) && (f3 != 3'b011);
      K_LUI:    return imm[11:0] == 12'h000;
      K_AUIPC:  return imm[11:0] == 12'h000;
      K_JAL:    return fits_s21(imm) && !imm[0];
      K_JALR:   return fits_s12(imm) && (f3 == 3'b000);
      default:  return 1'b0;
    endcase
  endfunction

  // Encode and legality-check the latched request.
  always_comb begin
    enc_word_s = encode_word(kind_r, funct3_r, alt_r, rd_r, rs1_r, rs2_r, imm_r);
    legal_s    = is_legal(kind_r, funct3_r, alt_r, imm_r);
  end

  assign req_ready = (state == IDLE);

  // Control FSM with registered memory-write outputs and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr_r   <= '0;
      count      <= '0;
      imem_we    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      full       <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'h0000_0000;
      kind_r     <= 4'd0;
      funct3_r   <= 3'd0;
      alt_r      <= 1'b0;
      rd_r       <= 5'd0;
      rs1_r      <= 5'd0;
      rs2_r      <= 5'd0;
      imm_r      <= 32'h0000_0000;
      last_r     <= 1'b0;
      enc_word_r <= 32'h0000_0000;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      if (clear) begin
        state    <= IDLE;
        wr_ptr_r <= '0;
        count    <= '0;
        full     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              kind_r   <= req_kind;
              funct3_r <= req_funct3;
              alt_r    <= req_alt;
              rd_r     <= req_rd;
              rs1_r    <= req_rs1;
              rs2_r    <= req_rs2;
              imm_r    <= req_imm;
              last_r   <= req_last;
              state    <= ENCODE;
            end else begin
              state <= IDLE;
            end
          end
          ENCODE: begin
            enc_word_r <= enc_word_s;
            if (legal_s) begin
              state <= WRITE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
          WRITE: begin
            imem_we    <= 1'b1;
            imem_addr  <= BASE_ADDR + (32'(wr_ptr_r) << 2);
            imem_wdata <= enc_word_r;
            wr_ptr_r   <= wr_ptr_r + PTR_ONE;
            count      <= count + CNT_ONE;
            done       <= last_r;
            if (wr_ptr_r == PTR_MAX) begin
              full  <= 1'b1;
              state <= FULL;
            end else begin
              state <= IDLE;
            end
          end
          FULL: begin
            full  <= 1'b1;
            state <= FULL;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (DEPTH_LOG2=2, BASE_ADDR=0).
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_kind = 4'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic        req_alt = 1'b0;
  logic [4:0]  req_rd = 5'd0;
  logic [4:0]  req_rs1 = 5'd0;
  logic [4:0]  req_rs2 = 5'd0;
  logic [31:0] req_imm = 32'd0;
  logic        req_last = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        done;
  logic        err;
  logic        full;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_encoder #(.DEPTH_LOG2(2), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_funct3(req_funct3), .req_alt(req_alt),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm), .req_last(req_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .done(done), .err(err), .full(full), .count(count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Present one request for a single handshake edge.
  task automatic send(input string tag, input logic [3:0] kind, input logic [2:0] f3,
                      input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_kind = kind; req_funct3 = f3; req_alt = alt;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_imm = imm; req_last = last; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_last = 1'b0;
  endtask

  // Write must appear exactly two cycles after the handshake.
  task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                              input logic last, input logic [31:0] cnt);
    step();
    check_eq({tag, "_we_early"}, 32'(imem_we), 32'd0);
    step();
    check_eq({tag, "_we"}, 32'(imem_we), 32'd1);
    check_eq({tag, "_addr"}, imem_addr, addr);
    check_eq({tag, "_data"}, imem_wdata, data);
    check_eq({tag, "_done"}, 32'(done), 32'(last));
    check_eq({tag, "_count"}, 32'(count), cnt);
  endtask

  // Illegal request: err one cycle after handshake, never a write.
  task automatic expect_err(input string tag, input logic [31:0] cnt);
    step();
    check_eq({tag, "_err"}, 32'(err), 32'd1);
    check_eq({tag, "_we0"}, 32'(imem_we), 32'd0);
    step();
    check_eq({tag, "_err_pulse"}, 32'(err), 32'd0);
    check_eq({tag, "_we1"}, 32'(imem_we), 32'd0);
    check_eq({tag, "_count"}, 32'(count), cnt);
  endtask

  initial begin
    step(); step(); step();
    check_eq("rst_we", 32'(imem_we), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0000_0000);
    check_eq("rst_wdata", imem_wdata, 32'h0000_0000);
    rst_n = 1'b1;
    step();
    check_eq("rst_ready", 32'(req_ready), 32'd1);

    send("add", 4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    expect_write("add", 32'h0, 32'h0020_81B3, 1'b0, 32'd1);
    step();
    check_eq("hold_we", 32'(imem_we), 32'd0);
    check_eq("hold_data", imem_wdata, 32'h0020_81B3);
    pulse_clear();

    send("addi", 4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    expect_write("addi", 32'h0, 32'hFFF0_0093, 1'b0, 32'd1);
    send("srai", 4'd1, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1'b0);
    expect_write("srai", 32'h4, 32'h4033_5293, 1'b0, 32'd2);
    pulse_clear();

    send("beq", 4'd4, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd8, 1'b0);
    expect_write("beq", 32'h0, 32'h0020_8463, 1'b0, 32'd1);
    send("beq_odd", 4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0);
    expect_err("beq_odd", 32'd1);
    send("kind9", 4'd9, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    expect_err("kind9", 32'd1);
    send("addi_big", 4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    expect_err("addi_big", 32'd1);
    send("lui_low", 4'd5, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h1234_5001, 1'b0);
    expect_err("lui_low", 32'd1);
    send("slli_alt", 4'd1, 3'd1, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, 1'b0);
    expect_err("slli_alt", 32'd1);
    send("jal_odd", 4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0);
    expect_err("jal_odd", 32'd1);
    send("store_f3", 4'd3, 3'd3, 1'b0, 5'd0, 5'd2, 5'd5, 32'd0, 1'b0);
    expect_err("store_f3", 32'd1);

    send("lui", 4'd5, 3'd0, 1'b0, 5'd10, 5'd7, 5'd9, 32'h1234_5000, 1'b1);
    expect_write("lui", 32'h4, 32'h1234_5537, 1'b1, 32'd2);
    send("sw", 4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC, 1'b0);
    expect_write("sw", 32'h8, 32'hFE51_2E23, 1'b0, 32'd3);
    send("jal", 4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b0);
    expect_write("jal", 32'hC, 32'h0010_00EF, 1'b0, 32'd4);
    check_eq("full_set", 32'(full), 32'd1);

    req_kind = 4'd0; req_rd = 5'd1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("full_ready", 32'(req_ready), 32'd0);
      check_eq("full_we", 32'(imem_we), 32'd0);
    end
    req_valid = 1'b0;
    check_eq("full_count", 32'(count), 32'd4);
    pulse_clear();
    check_eq("clr_full", 32'(full), 32'd0);
    check_eq("clr_count", 32'(count), 32'd0);
    send("jalr", 4'd8, 3'd0, 1'b0, 5'd1, 5'd5, 5'd0, 32'd4, 1'b0);
    expect_write("jalr", 32'h0, 32'h0042_80E7, 1'b0, 32'd1);

    // clear while the request sits in ENCODE
    send("enc_clr", 4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    pulse_clear();
    check_eq("enc_clr_we0", 32'(imem_we), 32'd0);
    check_eq("enc_clr_err", 32'(err), 32'd0);
    check_eq("enc_clr_count", 32'(count), 32'd0);
    step();
    check_eq("enc_clr_we1", 32'(imem_we), 32'd0);
    send("after_clr", 4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    expect_write("after_clr", 32'h0, 32'h0020_81B3, 1'b0, 32'd1);

    // reset while the request sits in WRITE
    send("wr_rst", 4'd1, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("wr_rst_we0", 32'(imem_we), 32'd0);
    check_eq("wr_rst_count", 32'(count), 32'd0);
    check_eq("wr_rst_wdata", imem_wdata, 32'h0000_0000);
    check_eq("wr_rst_done", 32'(done), 32'd0);
    step();
    check_eq("wr_rst_we1", 32'(imem_we), 32'd0);
    send("after_rst", 4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    expect_write("after_rst", 32'h0, 32'h0020_8463, 1'b0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of instruction-memory words reachable by the write pointer.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first written word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 clear  input  1  synchronous restart: pointer to 0, abandon any in-flight request.
REQ-006 req_valid / req_ready  input / output  1 / 1  request handshake; transfer when both are high at a rising edge.
REQ-007 req_kind  input  4  format: 0 R, 1 I_ARITH, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR; 9-15 illegal.
REQ-008 req_funct3  input  3  funct3 field.
REQ-009 req_alt  input  1  selects funct7 = 0100000 (SUB/SRA/SRAI), else 0000000.
REQ-010 req_rd, req_rs1, req_rs2  input  5 each  register indices.
REQ-011 req_imm  input  32  signed byte-level immediate, not pre-shifted.
REQ-012 req_last  input  1  marks the final instruction of a program.
REQ-013 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-014 imem_addr  output  32  BASE_ADDR + 4*wr_ptr.
REQ-015 imem_wdata  output  32  encoded RV32I instruction word.
REQ-016 done  output  1  one-cycle pulse on the write of a req_last word.
REQ-017 err  output  1  one-cycle pulse when a request is rejected as illegal.
REQ-018 full  output  1  high while the pointer has wrapped and no more writes are accepted.
REQ-019 count  output  DEPTH_LOG2+1  number of words written since reset or clear.

Function
REQ-020 FSM states IDLE, ENCODE, WRITE, FULL; req_ready = 1 only in IDLE.
REQ-021 IDLE: on handshake, latch all req_* fields and go to ENCODE.
REQ-022 ENCODE: register the encoded word and the legality flag; illegal -> err=1 and return to IDLE; legal -> go to WRITE.
REQ-023 WRITE: imem_we=1 with registered addr/data; increment wr_ptr and count; done=req_last; go to FULL if wr_ptr was 2^DEPTH_LOG2-1, else IDLE.
REQ-024 Latency: handshake at edge N -> imem_we high in cycle N+2; maximum throughput one word per 3 cycles.
REQ-025 Opcodes: R 0110011, I_ARITH 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
REQ-026 Field placement follows the RV32I base encoding for R/I/S/B/U/J; fields not used by a format are 0.
REQ-027 I_ARITH with funct3 001/101: bits[24:20]=imm[4:0], bits[31:25]=funct7 from req_alt; illegal if imm>31 unsigned, or req_alt with funct3 001.
REQ-028 Illegal cases: I, LOAD, STORE, JALR imm outside [-2048,2047]; BRANCH imm odd or outside [-4096,4094]; JAL imm odd or outside [-2^20, 2^20-2]; LUI/AUIPC imm[11:0]!=0.
REQ-029 Further illegal cases: R with req_alt and funct3 not 000/101; LOAD funct3 011/110/111; STORE funct3 >010; BRANCH funct3 010/011; JALR funct3 !=000; req_kind >8.
REQ-030 An illegal request causes no write and leaves wr_ptr and count unchanged.
REQ-031 FULL: hold until clear; req_ready=0; imem_we=0.
REQ-032 clear has priority over all states: next state IDLE, wr_ptr=0, count=0, no write or pulse that cycle, including mid-ENCODE and mid-WRITE.
REQ-033 imem_addr and imem_wdata hold their last values when imem_we=0.

Reset
REQ-034 While rst_n=0 at a rising edge: state IDLE, wr_ptr=0, count=0, imem_we=0, done=0, err=0, full=0, imem_addr=BASE_ADDR, imem_wdata=0.
REQ-035 rst_n has priority over clear; reset mid-operation discards the latched request with no write.

Verification
REQ-036 R ADD rd=3 rs1=1 rs2=2 -> imem_wdata 0x002081B3 at BASE_ADDR, two cycles after handshake.
REQ-037 I_ARITH ADDI rd=1 rs1=0 imm=-1 -> 0x FFF00093; then funct3=101 alt=1 rd=5 rs1=6 imm=3 -> 0x40335293 at BASE_ADDR+4.
REQ-038 BRANCH funct3=000 rs1=1 rs2=2 imm=8 -> 0x00208463; imm=7 -> err pulse, no imem_we, count unchanged.
REQ-039 LUI rd=10 imm=0x12345000 with req_last=1 -> 0x12345537 and done pulse in the same cycle as imem_we.
REQ-040 DEPTH_LOG2=2: four legal requests -> addresses 0x0/0x4/0x8/0xC, full=1, count=4; fifth request gets req_ready=0; clear -> next write at BASE_ADDR, count=1.
REQ-041 clear asserted in ENCODE, and separately rst_n=0 in WRITE -> no imem_we; the next accepted request writes at BASE_ADDR.
